// File: rtl/uart_tx_fifo_param.sv
// UART transmitter fed by a valid/ready transmit FIFO, with run-time frame format.
// The baud divisor and frame format are latched when each frame starts and held until it ends.
module uart_tx_fifo_param #(
  parameter int DATA_WIDTH     = 8,
  parameter int BAUD_DIV_WIDTH = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int DATA_LEN_WIDTH = $clog2(DATA_WIDTH),
  parameter int LEVEL_WIDTH    = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      a_rst_i,
  input  logic                      enable_i,
  input  logic [BAUD_DIV_WIDTH-1:0] baud_div_i,
  input  logic [DATA_LEN_WIDTH-1:0] data_len_i,
  input  logic [1:0]                parity_mode_i,
  input  logic                      stop_bits_i,
  input  logic [DATA_WIDTH-1:0]     s_data_i,
  input  logic                      s_valid_i,
  output logic                      s_ready_o,
  output logic [LEVEL_WIDTH-1:0]    fifo_level_o,
  output logic                      busy_o,
  output logic                      frame_done_o,
  output logic                      tx_o
);
  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam logic [DATA_LEN_WIDTH-1:0] MIN_LEN    = DATA_LEN_WIDTH'(4);
  localparam logic [LEVEL_WIDTH-1:0]    FULL_LEVEL = LEVEL_WIDTH'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  logic [DATA_WIDTH-1:0]     mem_q [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEVEL_WIDTH-1:0]    level_q, level_d;
  logic                      ready_q, ready_d;
  logic                      push, pop;

  state_e                    state_q, state_d;
  logic [BAUD_DIV_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
  logic [DATA_LEN_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic                      par_q, par_d;
  logic [BAUD_DIV_WIDTH-1:0] baud_div_q, baud_div_d;
  logic [DATA_LEN_WIDTH-1:0] data_len_q, data_len_d;
  logic                      par_en_q, par_en_d, par_odd_q, par_odd_d;
  logic                      stop2_q, stop2_d;
  logic                      tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic                      tick, start_frame;

  // s_ready is the registered !full of the post-edge level, so it never anticipates a pop.
  always_comb begin
    push     = s_valid_i && ready_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
    ready_d = (level_d != FULL_LEVEL);
  end

  // NOTE: storage has no reset; entries are only ever read behind a non-zero level.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data_i;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    baud_div_d  = baud_div_q;
    data_len_d  = data_len_q;
    par_en_d    = par_en_q;
    par_odd_d   = par_odd_q;
    stop2_d     = stop2_q;
    done_d      = 1'b0;
    pop         = 1'b0;
    start_frame = 1'b0;
    tick        = (baud_cnt_q == baud_div_q);

    if (state_q != IDLE) begin
      baud_cnt_d = tick ? '0 : baud_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: start_frame = enable_i && (level_q != '0);
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          par_d   = par_q ^ shift_q[0];
          shift_d = shift_q >> 1;
          if (bit_cnt_q == data_len_q) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d   = STOP;
          bit_cnt_d = '0;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop2_q && (bit_cnt_q == '0)) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else begin
            done_d      = 1'b1;
            state_d     = IDLE;
            start_frame = enable_i && (level_q != '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A start from IDLE or straight out of STOP pops the head word and freezes the format.
    if (start_frame) begin
      pop        = 1'b1;
      state_d    = START;
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
      shift_d    = mem_q[rd_ptr_q];
      par_d      = 1'b0;
      baud_div_d = baud_div_i;
      data_len_d = (data_len_i < MIN_LEN) ? MIN_LEN : data_len_i;
      par_en_d   = parity_mode_i[0] ^ parity_mode_i[1];
      par_odd_d  = parity_mode_i[1];
      stop2_d    = stop_bits_i;
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d ^ par_odd_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ready_q    <= 1'b0;
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      baud_div_q <= '0;
      data_len_q <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ready_q    <= ready_d;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      baud_div_q <= baud_div_d;
      data_len_q <= data_len_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign s_ready_o    = ready_q;
  assign fifo_level_o = level_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign tx_o         = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Self-checking bench for uart_tx_fifo_param: a queue-based FIFO model plus a line monitor
// that rebuilds each expected frame from the data word and the frame-format rules.
module tb_uart_tx_fifo_param;
  localparam int DW    = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 4;
  localparam int LW    = 3;
  localparam int LVW   = 3;

  logic           clk_i = 1'b0;
  logic           a_rst_i = 1'b0;
  logic           enable_i = 1'b0;
  logic [BW-1:0]  baud_div_i = '0;
  logic [LW-1:0]  data_len_i = '0;
  logic [1:0]     parity_mode_i = '0;
  logic           stop_bits_i = 1'b0;
  logic [DW-1:0]  s_data_i = '0;
  logic           s_valid_i = 1'b0;
  logic           s_ready_o;
  logic [LVW-1:0] fifo_level_o;
  logic           busy_o;
  logic           frame_done_o;
  logic           tx_o;

  uart_tx_fifo_param #(
    .DATA_WIDTH(DW), .BAUD_DIV_WIDTH(BW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .a_rst_i(a_rst_i), .enable_i(enable_i), .baud_div_i(baud_div_i),
    .data_len_i(data_len_i), .parity_mode_i(parity_mode_i), .stop_bits_i(stop_bits_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .fifo_level_o(fifo_level_o), .busy_o(busy_o), .frame_done_o(frame_done_o), .tx_o(tx_o)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line bits of one frame, first bit at index 0; returns the number of bits.
  function automatic int build_frame(input logic [DW-1:0] word, input logic [LW-1:0] len_field,
                                     input logic [1:0] pm, input logic sb, output logic [15:0] bits);
    int  nd;
    int  n;
    logic p;
    nd   = (len_field < 4) ? 5 : int'(len_field) + 1;
    bits = '1;
    p    = 1'b0;
    bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < nd; i++) begin
      bits[n] = word[i];
      p = p ^ word[i];
      n++;
    end
    if (pm == 2'b01) begin
      bits[n] = p;
      n++;
    end else if (pm == 2'b10) begin
      bits[n] = ~p;
      n++;
    end
    n += sb ? 2 : 1;
    return n;
  endfunction

  // Reference model state; written only by the monitor below.
  logic [DW-1:0] model_q[$];
  bit            mon_en = 1'b0;
  bit            mon_active = 1'b0;
  bit            expect_done = 1'b0;
  bit            want_start = 1'b0;
  logic [15:0]   exp_bits = '1;
  logic [DW-1:0] mon_word;
  int            exp_n = 0;
  int            bit_clks = 1;
  int            pos = 0;
  int            done_cnt = 0;

  always @(negedge clk_i) begin
    if (!mon_en) begin
      model_q.delete();
      mon_active  = 1'b0;
      expect_done = 1'b0;
      want_start  = 1'b0;
    end else begin
      if (!mon_active) begin
        if (expect_done) begin
          check("frame_done_pulse", frame_done_o, 1);
          if (frame_done_o === 1'b1) done_cnt++;
        end else begin
          check("frame_done_quiet", frame_done_o, 0);
        end
        expect_done = 1'b0;
        check("start_when_due", tx_o, want_start ? 0 : 1);
        if (tx_o === 1'b0) begin
          if (model_q.size() == 0) begin
            check("start_with_empty_fifo", model_q.size(), 1);
          end else begin
            mon_word   = model_q.pop_front();
            exp_n      = build_frame(mon_word, data_len_i, parity_mode_i, stop_bits_i, exp_bits);
            bit_clks   = int'(baud_div_i) + 1;
            pos        = 0;
            mon_active = 1'b1;
          end
        end else begin
          check("idle_busy", busy_o, 0);
        end
      end
      if (mon_active) begin
        check("tx_bit", tx_o, exp_bits[pos / bit_clks]);
        check("busy_in_frame", busy_o, 1);
        if (pos > 0) check("no_early_done", frame_done_o, 0);
        pos++;
        if (pos == exp_n * bit_clks) begin
          mon_active  = 1'b0;
          expect_done = 1'b1;
        end
      end
      check("fifo_level", fifo_level_o, model_q.size());
      check("s_ready", s_ready_o, model_q.size() < DEPTH);
      want_start = !mon_active && enable_i && (model_q.size() > 0);
      if (s_valid_i && s_ready_o) model_q.push_back(s_data_i);
    end
  end

  task automatic push_word(input logic [DW-1:0] d);
    int k;
    s_data_i  = d;
    s_valid_i = 1'b1;
    k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (!s_ready_o && k < 500);
    check("push_timeout", k < 500, 1);
    @(posedge clk_i);
    #1 s_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((mon_active || expect_done || model_q.size() != 0) && k < budget) begin
      @(posedge clk_i);
      #1;
      k++;
    end
    check("wait_idle_timeout", k < budget, 1);
  endtask

  task automatic set_cfg(input int baud, input int len, input int pm, input int sb);
    baud_div_i    = BW'(baud);
    data_len_i    = LW'(len);
    parity_mode_i = 2'(pm);
    stop_bits_i   = sb[0];
  endtask

  initial begin
    int k;
    int d0;
    #1 a_rst_i = 1'b1;
    #1;
    check("rst_tx", tx_o, 1);
    check("rst_ready", s_ready_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", frame_done_o, 0);
    check("rst_level", fifo_level_o, 0);
    repeat (3) @(posedge clk_i);
    #1 a_rst_i = 1'b0;
    #1 check("ready_before_first_edge", s_ready_o, 0);
    @(posedge clk_i);
    #1 check("ready_after_first_edge", s_ready_o, 1);
    mon_en = 1'b1;

    // 8N1, 0xA5, 4 clocks per bit; tx must drop one edge after the push edge.
    set_cfg(3, 7, 0, 0);
    enable_i = 1'b1;
    push_word(8'hA5);
    check("latency_still_idle", tx_o, 1);
    @(posedge clk_i);
    #1 check("latency_start_bit", tx_o, 0);
    wait_idle(500);

    // 7E2 with 0x41.
    set_cfg(3, 6, 1, 1);
    push_word(8'h41);
    wait_idle(500);

    // 5-bit frames: odd and even parity of 0x1F, then upper bits only.
    set_cfg(1, 4, 2, 0);
    push_word(8'h1F);
    wait_idle(500);
    set_cfg(1, 4, 1, 0);
    push_word(8'h1F);
    wait_idle(500);
    set_cfg(1, 4, 0, 0);
    push_word(8'hE0);
    wait_idle(500);

    // Fill the FIFO while disabled, then drain back to back.
    set_cfg(0, 7, 1, 0);
    enable_i  = 1'b0;
    s_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data_i = DW'(8'h30 + i);
      @(posedge clk_i);
      #1;
    end
    s_valid_i = 1'b0;
    check("full_level", fifo_level_o, 4);
    check("full_ready", s_ready_o, 0);
    d0 = done_cnt;
    enable_i = 1'b1;
    wait_idle(1000);
    check("b2b_done_count", done_cnt - d0, 4);

    // Format changes in mid-frame apply only to the following frame.
    set_cfg(2, 7, 0, 0);
    push_word(8'h96);
    push_word(8'h3C);
    repeat (8) @(posedge clk_i);
    #1 set_cfg(5, 5, 2, 1);
    wait_idle(1000);

    // Dropping enable mid-frame lets the frame finish and leaves the next word queued.
    set_cfg(2, 7, 0, 0);
    push_word(8'h5A);
    push_word(8'hC3);
    repeat (6) @(posedge clk_i);
    #1 enable_i = 1'b0;
    k = 0;
    while ((mon_active || expect_done) && k < 500) begin
      @(posedge clk_i);
      #1;
      k++;
    end
    check("disable_frame_end_timeout", k < 500, 1);
    repeat (10) @(posedge clk_i);
    #1;
    check("disable_level", fifo_level_o, 1);
    check("disable_busy", busy_o, 0);
    enable_i = 1'b1;
    wait_idle(500);

    // Randomised formats and push patterns; the format only changes while fully idle.
    for (int it = 0; it < 25; it++) begin
      set_cfg($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 1));
      enable_i = $urandom_range(0, 1);
      for (int c = 0; c < 10; c++) begin
        s_valid_i = $urandom_range(0, 1);
        s_data_i  = DW'($urandom);
        if ($urandom_range(0, 7) == 0) enable_i = ~enable_i;
        @(posedge clk_i);
        #1;
      end
      s_valid_i = 1'b0;
      enable_i  = 1'b1;
      wait_idle(3000);
    end

    // Asynchronous reset in mid-frame clears the line and the FIFO without a clock edge.
    set_cfg(3, 7, 0, 0);
    push_word(8'hF0);
    push_word(8'h0F);
    push_word(8'hAA);
    repeat (6) @(posedge clk_i);
    #1 mon_en = 1'b0;
    #2 a_rst_i = 1'b1;
    #1;
    check("midrst_tx", tx_o, 1);
    check("midrst_level", fifo_level_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_ready", s_ready_o, 0);
    repeat (2) @(posedge clk_i);
    #1 a_rst_i = 1'b0;
    @(posedge clk_i);
    #1 check("post_rst_ready", s_ready_o, 1);
    mon_en = 1'b1;
    push_word(8'h81);
    wait_idle(500);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
